// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: request FIFO plus a three-state issue FSM that drives an
// external combinational ALU one operation at a time and returns each result,
// tagged with its sequence number, over a valid/ready response channel.
// Optional build macro ALU_ISSUE_ZCHECK_EN adds a zero-flag consistency check
// that drives rsp_err; without it rsp_err is tied low.
module alu_issue_ctrl #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_z,
    output logic [3:0]       rsp_tag,
    output logic             rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // FIFO storage: data only, never reset; validity comes from the pointers.
    logic [WIDTH-1:0] fifo_a   [DEPTH];
    logic [WIDTH-1:0] fifo_b   [DEPTH];
    logic [1:0]       fifo_sel [DEPTH];
    logic [3:0]       fifo_tag [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wptr, rptr;
    logic        full, empty;
    logic        push, pop;
    logic [3:0]  tag_cnt;

    // Issue stage (_p0): operands currently presented to the ALU.
    logic [WIDTH-1:0] op_a_p0, op_b_p0;
    logic [1:0]       op_sel_p0;
    logic [3:0]       op_tag_p0;

    // Response stage (_p1): registered ALU result held until accepted.
    logic             vld_p1;
    logic [WIDTH-1:0] rsp_c_p1;
    logic             rsp_z_p1;
    logic [3:0]       rsp_tag_p1;

    // FSM action strobes
    logic capture, rsp_clr;

    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty     = (wptr == rptr);
    assign req_ready = !full;
    assign push      = req_valid && !full;

    // FIFO write port; storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wptr[AW-1:0]]   <= req_a;
            fifo_b[wptr[AW-1:0]]   <= req_b;
            fifo_sel[wptr[AW-1:0]] <= req_sel;
            fifo_tag[wptr[AW-1:0]] <= tag_cnt;
        end
    end

    // FIFO pointers and the sequence tag counter (wraps 15 -> 0 naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            tag_cnt <= 4'd0;
        end else begin
            if (push) begin
                wptr    <= wptr + 1'b1;
                tag_cnt <= tag_cnt + 4'd1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and action strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                capture   = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_clr = 1'b1;
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue stage: load operands on pop, hold them otherwise so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            op_sel_p0 <= 2'd0;
            op_tag_p0 <= 4'd0;
        end else if (pop) begin
            op_a_p0   <= fifo_a[rptr[AW-1:0]];
            op_b_p0   <= fifo_b[rptr[AW-1:0]];
            op_sel_p0 <= fifo_sel[rptr[AW-1:0]];
            op_tag_p0 <= fifo_tag[rptr[AW-1:0]];
        end
    end

    assign alu_a   = op_a_p0;
    assign alu_b   = op_b_p0;
    assign alu_sel = op_sel_p0;

    // Response stage: result fields change only on the edge leaving ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            rsp_c_p1   <= '0;
            rsp_z_p1   <= 1'b0;
            rsp_tag_p1 <= 4'd0;
        end else begin
            if (capture) begin
                vld_p1     <= 1'b1;
                rsp_c_p1   <= alu_c;
                rsp_z_p1   <= alu_z;
                rsp_tag_p1 <= op_tag_p0;
            end else if (rsp_clr) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_c     = rsp_c_p1;
    assign rsp_z     = rsp_z_p1;
    assign rsp_tag   = rsp_tag_p1;

`ifdef ALU_ISSUE_ZCHECK_EN
    logic err_p1;

    // True when the ALU's zero flag disagrees with its own result.
    function automatic logic zero_mismatch(input logic [WIDTH-1:0] c, input logic z);
        return (c == '0) != z;
    endfunction

    // Consistency flag captured alongside the result and held with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
        end else if (capture) begin
            err_p1 <= zero_mismatch(alu_c, alu_z);
        end
    end

    assign rsp_err = err_p1;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table of directed vectors, directed
// latency/backpressure/tag-wrap/reset sequences, and randomized traffic
// checked by an in-order response scoreboard.
module tb_alu_issue_ctrl;

    localparam int W = 18;
`ifdef ALU_ISSUE_ZCHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic [1:0]   req_sel;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [1:0]   alu_sel;
    logic         alu_z;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_c;
    logic         rsp_z;
    logic [3:0]   rsp_tag;
    logic         rsp_err;
    logic         ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_c(alu_c), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Bench ALU; ovr forces an inconsistent c=5, z=1 pair.
    always_comb begin
        alu_c = ovr ? W'(5) : alu_fn(alu_a, alu_b, alu_sel);
        alu_z = ovr ? 1'b1 : (alu_fn(alu_a, alu_b, alu_sel) == '0);
    end

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        logic [3:0]   tag;
        logic         err;
    } rsp_t;

    rsp_t     exp_q[$];
    logic [3:0] tag_m = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: checks each handshake in order and hold-stability under backpressure.
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_c;
    logic         hold_z, hold_err;
    logic [3:0]   hold_tag;
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_c", 32'(rsp_c), 32'(hold_c));
                chk("hold_z", 32'(rsp_z), 32'(hold_z));
                chk("hold_tag", 32'(rsp_tag), 32'(hold_tag));
                chk("hold_err", 32'(rsp_err), 32'(hold_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got tag %0d c %0h expected no response", rsp_tag, rsp_c);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_c", 32'(rsp_c), 32'(e.c));
                    chk("rsp_z", 32'(rsp_z), 32'(e.z));
                    chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            hold_v   = rsp_valid && !rsp_ready;
            hold_c   = rsp_c;
            hold_z   = rsp_z;
            hold_tag = rsp_tag;
            hold_err = rsp_err;
        end
    end

    // Offer one request until accepted; record the expected response on acceptance.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        int   n  = 0;
        bit   ok = 1'b0;
        rsp_t e;
        req_a = a; req_b = b; req_sel = sel; req_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no acceptance expected within 300 cycles");
        end else begin
            e.c   = ovr ? W'(5) : alu_fn(a, b, sel);
            e.z   = ovr ? 1'b1 : (alu_fn(a, b, sel) == '0);
            e.tag = tag_m;
            e.err = ZCHK && ((e.c == '0) != e.z);
            exp_q.push_back(e);
            tag_m = tag_m + 4'd1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        tag_m = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic [1:0]   sel;
        logic         ov;
        logic [W-1:0] ec;
        logic         ez;
        logic         eerr;
    } vec_t;

    vec_t vt[9];

    initial begin
        int   n;
        bit   rnd_done;

        vt[0] = '{18'h00001, 18'h00002, 2'd0, 1'b0, 18'h00003, 1'b0, 1'b0};
        vt[1] = '{18'h00001, 18'h00002, 2'd1, 1'b0, 18'h3FFFF, 1'b0, 1'b0};
        vt[2] = '{18'h00001, 18'h00002, 2'd2, 1'b0, 18'h00000, 1'b1, 1'b0};
        vt[3] = '{18'h00001, 18'h00002, 2'd3, 1'b0, 18'h00003, 1'b0, 1'b0};
        vt[4] = '{18'h3FFFF, 18'h00001, 2'd0, 1'b0, 18'h00000, 1'b1, 1'b0};
        vt[5] = '{18'h00000, 18'h00000, 2'd1, 1'b0, 18'h00000, 1'b1, 1'b0};
        vt[6] = '{18'h2AAAA, 18'h15555, 2'd3, 1'b0, 18'h3FFFF, 1'b0, 1'b0};
        vt[7] = '{18'h12345, 18'h12345, 2'd1, 1'b0, 18'h00000, 1'b1, 1'b0};
        vt[8] = '{18'h00001, 18'h00001, 2'd0, 1'b1, 18'h00005, 1'b1, ZCHK};

        req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = 2'd0;
        rsp_ready = 1'b0; ovr = 1'b0;
        rst_n = 1'b1;
        #1;
        do_reset();

        // Reset values
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_rsp_c", 32'(rsp_c), 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;

        // Single request latency: valid rises after the second edge past acceptance
        rsp_ready = 1'b1;
        push(18'd1, 18'd2, 2'd0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        chk("single_c", 32'(rsp_c), 32'd3);
        chk("single_tag", 32'(rsp_tag), 32'd0);
        drain();

        // Back-to-back burst, tags 0..3
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(18'd1, 18'd2, 2'(i));
        drain();

        // Table-driven vectors, one at a time
        for (int i = 0; i < 9; i++) begin
            ovr = vt[i].ov;
            push(vt[i].a, vt[i].b, vt[i].sel);
            drain();
            @(negedge clk);
            chk("vec_c", 32'(rsp_c), 32'(vt[i].ec));
            chk("vec_z", 32'(rsp_z), 32'(vt[i].ez));
            chk("vec_err", 32'(rsp_err), 32'(vt[i].eerr));
            chk("vec_idle", 32'(rsp_valid), 32'd0);
            ovr = 1'b0;
            @(posedge clk);
            #1;
        end

        // Backpressure: 1 in service + 4 queued, then further requests stall
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(18'(100 + i), 18'(i), 2'(i));
        req_a = 18'h0BEEF; req_b = 18'd0; req_sel = 2'd3; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Tag wrap: 17 requests, tags 0..15 then 0
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(18'(i), 18'd7, 2'd0);
        drain();
        @(negedge clk);
        chk("wrap_last_tag", 32'(rsp_tag), 32'd0);
        @(posedge clk);
        #1;

        // Reset while in RESP with 2 entries queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(18'(i + 9), 18'd3, 2'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_in_resp", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rsp_c", 32'(rsp_c), 32'd0);
        chk("mid_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        tag_m = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push(18'd4, 18'd4, 2'd2);
        drain();

        // Randomized traffic with random response backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(18'($urandom), 18'($urandom), 2'($urandom_range(0, 3)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
